// File: rtl/strobe_gen_ctrl_if.sv
// Sensor-side sync inputs, run-time settings and strobe outputs of strobe_gen_ctrl.
// master: the environment that drives the sync inputs and settings and observes the strobe.
// slave : strobe_gen_ctrl itself.
//   i_strobe, i_pll_lock, i_fval, i_lval    asynchronous sensor / deserializer signals
//   i_acquisition_start, i_stream_enable    run enables (clk domain)
//   i_trigger, i_trigger_mode               trigger pulse and mode select (0 = continuous)
//   i_extend_lines                          extend window length in lines
//   i_strobe_delay, i_strobe_width          delay / width in clk cycles (width 0 = level)
//   i_strobe_polarity                       0 = active-high, 1 = active-low
//   o_strobe, o_lperiod, o_strobe_cnt       strobe pin, measured line period, strobe count
interface strobe_gen_ctrl_if #(
    parameter int unsigned LPERIOD_WIDTH = 16,
    parameter int unsigned DELAY_WIDTH   = 16,
    parameter int unsigned CNT_WIDTH     = 16
);
    logic                     i_strobe;
    logic                     i_pll_lock;
    logic                     i_fval;
    logic                     i_lval;
    logic                     i_acquisition_start;
    logic                     i_stream_enable;
    logic                     i_trigger;
    logic                     i_trigger_mode;
    logic [3:0]               i_extend_lines;
    logic [DELAY_WIDTH-1:0]   i_strobe_delay;
    logic [DELAY_WIDTH-1:0]   i_strobe_width;
    logic                     i_strobe_polarity;
    logic                     o_strobe;
    logic [LPERIOD_WIDTH-1:0] o_lperiod;
    logic [CNT_WIDTH-1:0]     o_strobe_cnt;

    modport master (
        output i_strobe, i_pll_lock, i_fval, i_lval,
        output i_acquisition_start, i_stream_enable, i_trigger, i_trigger_mode,
        output i_extend_lines, i_strobe_delay, i_strobe_width, i_strobe_polarity,
        input  o_strobe, o_lperiod, o_strobe_cnt
    );

    modport slave (
        input  i_strobe, i_pll_lock, i_fval, i_lval,
        input  i_acquisition_start, i_stream_enable, i_trigger, i_trigger_mode,
        input  i_extend_lines, i_strobe_delay, i_strobe_width, i_strobe_polarity,
        output o_strobe, o_lperiod, o_strobe_cnt
    );
endinterface

// File: rtl/strobe_gen_ctrl.sv
// Flash-strobe generator for rolling-shutter sensors. Measures the line period every
// frame, derives the post-frame extend window from it, and turns a qualified sensor
// strobe edge into a delayed fixed-width or level strobe of selectable polarity.
// Ports:
//   clk    pixel clock
//   reset  asynchronous, active-high
//   bus    strobe_gen_ctrl_if slave (sync inputs, settings, strobe outputs)
// EXTEND_WIDTH must be at least LPERIOD_WIDTH+4 so the extend product cannot overflow.
module strobe_gen_ctrl #(
    parameter int unsigned LPERIOD_WIDTH = 16,
    parameter int unsigned EXTEND_WIDTH  = 24,
    parameter int unsigned DELAY_WIDTH   = 16,
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned FIX_TIME      = 1650
) (
    input  logic                clk,
    input  logic                reset,
    strobe_gen_ctrl_if.slave    bus
);

    localparam int unsigned LW = LPERIOD_WIDTH;
    localparam int unsigned EW = EXTEND_WIDTH;
    localparam int unsigned DW = DELAY_WIDTH;
    localparam int unsigned CW = CNT_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } state_t;

    // 3-flop synchronisers; level is bit 1, edges compare bits 2:1
    logic [2:0] strobe_sync, pll_sync, fval_sync, lval_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe_sync <= '0;
            pll_sync    <= '0;
            fval_sync   <= '0;
            lval_sync   <= '0;
        end else begin
            strobe_sync <= {strobe_sync[1:0], bus.i_strobe};
            pll_sync    <= {pll_sync[1:0],    bus.i_pll_lock};
            fval_sync   <= {fval_sync[1:0],   bus.i_fval};
            lval_sync   <= {lval_sync[1:0],   bus.i_lval};
        end
    end

    logic strobe_rise, pll_level, pll_rise, fval_level, fval_rise, fval_fall, lval_rise;

    assign strobe_rise = strobe_sync[1] & ~strobe_sync[2];
    assign pll_level   = pll_sync[1];
    assign pll_rise    = pll_sync[1] & ~pll_sync[2];
    assign fval_level  = fval_sync[1];
    assign fval_rise   = fval_sync[1] & ~fval_sync[2];
    assign fval_fall   = ~fval_sync[1] & fval_sync[2];
    assign lval_rise   = lval_sync[1] & ~lval_sync[2];

    // Line period: count clocks between the first two lval rises of a frame
    logic [1:0]    lval_cnt;
    logic [LW-1:0] period_cnt;
    logic [LW-1:0] lperiod;
    logic          load_lperiod;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lval_cnt     <= '0;
            period_cnt   <= '0;
            lperiod      <= '0;
            load_lperiod <= 1'b0;
        end else begin
            if (!fval_level)
                lval_cnt <= '0;
            else if (lval_rise && lval_cnt != 2'd2)
                lval_cnt <= lval_cnt + 2'd1;

            if (lval_cnt == 2'd0)
                period_cnt <= '0;
            else if (lval_cnt == 2'd1 && period_cnt != '1)
                period_cnt <= period_cnt + LW'(1);

            load_lperiod <= fval_level & lval_rise & (lval_cnt == 2'd1);
            if (load_lperiod)
                lperiod <= period_cnt;
        end
    end

    // Extend window after the frame: lines * period minus the pre-exposure offset
    logic [EW-1:0] extend_prod;
    logic [EW-1:0] extend_len_next;
    logic [EW-1:0] extend_length;
    logic [EW-1:0] extend_cnt;
    logic          fval_extend;

    assign extend_prod     = EW'(bus.i_extend_lines) * EW'(lperiod);
    assign extend_len_next = (extend_prod > EW'(FIX_TIME)) ? extend_prod - EW'(FIX_TIME) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            extend_length <= '1;
            extend_cnt    <= '0;
            fval_extend   <= 1'b0;
        end else begin
            if (fval_fall)
                extend_length <= extend_len_next;

            // Held at 0 through the fall cycle so the new length is compared from 0
            if (fval_level || fval_fall)
                extend_cnt <= '0;
            else if (extend_cnt <= extend_length && extend_cnt != '1)
                extend_cnt <= extend_cnt + EW'(1);

            if (fval_rise)
                fval_extend <= 1'b1;
            else if (!fval_level && !fval_fall && extend_cnt == extend_length)
                fval_extend <= 1'b0;
        end
    end

    // Run enable and trigger qualification
    logic strobe_enable, trigger_status, first_enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe_enable  <= 1'b0;
            trigger_status <= 1'b0;
            first_enable   <= 1'b0;
        end else begin
            strobe_enable <= bus.i_stream_enable & bus.i_acquisition_start;

            if (!strobe_enable)
                trigger_status <= 1'b0;
            else if (bus.i_trigger)
                trigger_status <= 1'b1;
            else if (pll_rise)
                trigger_status <= 1'b0;

            if (!strobe_enable)
                first_enable <= 1'b0;
            else if (trigger_status && pll_rise)
                first_enable <= 1'b1;
            else if (fval_rise)
                first_enable <= 1'b0;
        end
    end

    logic allow, abort;

    assign allow = bus.i_trigger_mode ? (first_enable & ~fval_level & ~fval_rise)
                                      : (pll_level & ~fval_extend);
    assign abort = bus.i_trigger_mode ? (fval_rise | ~first_enable)
                                      : (~pll_level | fval_extend);

    // Strobe FSM: state register
    state_t        state, next_state;
    logic [DW-1:0] tmr;
    logic          tmr_clr, tmr_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Strobe FSM: next state and timer control; abort wins over normal transitions
    always_comb begin
        next_state = state;
        tmr_clr    = 1'b0;
        tmr_inc    = 1'b0;
        if (!strobe_enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (strobe_rise && allow) begin
                        tmr_clr    = 1'b1;
                        next_state = (bus.i_strobe_delay == '0) ? PULSE : DELAY;
                    end
                end
                DELAY: begin
                    if (abort) begin
                        next_state = IDLE;
                    end else if (tmr == bus.i_strobe_delay - DW'(1)) begin
                        next_state = PULSE;
                        tmr_clr    = 1'b1;
                    end else begin
                        tmr_inc = 1'b1;
                    end
                end
                PULSE: begin
                    if (abort)
                        next_state = IDLE;
                    else if (bus.i_strobe_width != '0 && tmr == bus.i_strobe_width - DW'(1))
                        next_state = IDLE;
                    else
                        tmr_inc = 1'b1;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Delay/width timer, pulse flag and emitted-strobe counter
    logic          active;
    logic [CW-1:0] strobe_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr        <= '0;
            active     <= 1'b0;
            strobe_cnt <= '0;
        end else begin
            if (tmr_clr)
                tmr <= '0;
            else if (tmr_inc)
                tmr <= tmr + DW'(1);

            active <= (next_state == PULSE);

            if (next_state == PULSE && state != PULSE)
                strobe_cnt <= strobe_cnt + CW'(1);
        end
    end

    assign bus.o_strobe     = active ^ bus.i_strobe_polarity;
    assign bus.o_lperiod    = lperiod;
    assign bus.o_strobe_cnt = strobe_cnt;

endmodule

// File: tb/tb_strobe_gen_ctrl.sv
// Self-checking bench for strobe_gen_ctrl. Every strobe stimulus that should produce a
// pulse pushes its expected start cycle and length; a monitor pops and compares on each
// observed pulse. Inputs are driven on the falling edge; outputs sampled 1 ns after rise.
module tb_strobe_gen_ctrl;

    localparam int unsigned LPW = 10;
    localparam int unsigned EW  = 24;
    localparam int unsigned DW  = 16;
    localparam int unsigned CW  = 4;
    localparam int unsigned FIX = 10;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    strobe_gen_ctrl_if #(.LPERIOD_WIDTH(LPW), .DELAY_WIDTH(DW), .CNT_WIDTH(CW)) sif ();

    strobe_gen_ctrl #(
        .LPERIOD_WIDTH (LPW),
        .EXTEND_WIDTH  (EW),
        .DELAY_WIDTH   (DW),
        .CNT_WIDTH     (CW),
        .FIX_TIME      (FIX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    typedef struct {
        int unsigned st;
        int unsigned len;
    } pulse_t;

    pulse_t      sb[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc      = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Strobe rise in the current cycle c; asserted output expected from cycle c+3+delay
    task automatic fire(input bit expect_pulse, input int unsigned delay, input int unsigned len);
        sif.i_strobe = 1'b1;
        if (expect_pulse)
            sb.push_back('{st: cyc + 3 + delay, len: len});
        tick(2);
        sif.i_strobe = 1'b0;
    endtask

    task automatic line();
        sif.i_lval = 1'b1;
        tick(5);
        sif.i_lval = 1'b0;
    endtask

    // Pulse monitor / scoreboard consumer
    initial begin
        bit          prev_act = 1'b0;
        bit          act;
        int unsigned rise_cyc = 0;
        pulse_t      e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            act = sif.o_strobe ^ sif.i_strobe_polarity;
            if (act && !prev_act)
                rise_cyc = cyc;
            if (!act && prev_act) begin
                if (sb.size() == 0) begin
                    check("pulse_expected", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("pulse_start", rise_cyc, e.st);
                    check("pulse_len", cyc - rise_cyc, e.len);
                end
            end
            prev_act = act;
        end
    end

    initial begin
        reset                   = 1'b1;
        sif.i_strobe            = 1'b0;
        sif.i_pll_lock          = 1'b1;
        sif.i_fval              = 1'b0;
        sif.i_lval              = 1'b0;
        sif.i_acquisition_start = 1'b1;
        sif.i_stream_enable     = 1'b1;
        sif.i_trigger           = 1'b0;
        sif.i_trigger_mode      = 1'b0;
        sif.i_extend_lines      = 4'd0;
        sif.i_strobe_delay      = '0;
        sif.i_strobe_width      = DW'(3);
        sif.i_strobe_polarity   = 1'b0;

        // Reset state
        tick(3);
        check("rst_strobe", sif.o_strobe, 0);
        check("rst_lperiod", sif.o_lperiod, 0);
        check("rst_cnt", sif.o_strobe_cnt, 0);
        sif.i_strobe_polarity = 1'b1;
        #1;
        check("rst_strobe_pol1", sif.o_strobe, 1);
        sif.i_strobe_polarity = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(5);

        // Continuous, delay 0 and delay 5, width 3
        fire(1'b1, 0, 3);
        tick(10);
        check("cnt_first", sif.o_strobe_cnt, 1);
        sif.i_strobe_delay = DW'(5);
        fire(1'b1, 5, 3);
        tick(15);
        check("cnt_delayed", sif.o_strobe_cnt, 2);

        // Frame with 696-cycle lines, then extend window 7*696-10 = 4862
        sif.i_strobe_delay = '0;
        sif.i_extend_lines = 4'd7;
        sif.i_fval = 1'b1;
        tick(10);
        line();
        tick(691);
        line();
        tick(691);
        line();
        tick(20);
        check("lperiod_696", sif.o_lperiod, 696);
        sif.i_fval = 1'b0;
        tick(4000);
        fire(1'b0, 0, 0);
        tick(898);
        fire(1'b1, 0, 3);
        tick(10);
        check("cnt_after_extend", sif.o_strobe_cnt, 3);

        // Level mode ended by the next frame start through fval_extend
        sif.i_strobe_width = '0;
        fire(1'b1, 0, 21);
        tick(18);
        sif.i_fval = 1'b1;
        tick(10);
        sif.i_extend_lines = 4'd0;
        sif.i_fval = 1'b0;
        tick(10);
        check("cnt_level", sif.o_strobe_cnt, 4);

        // Trigger mode: arm, pll relock, pulse aborted by fval rise, then no re-arm
        sif.i_trigger_mode = 1'b1;
        sif.i_strobe_width = DW'(200);
        tick(5);
        sif.i_trigger = 1'b1;
        tick(1);
        sif.i_trigger = 1'b0;
        tick(2);
        sif.i_pll_lock = 1'b0;
        tick(5);
        sif.i_pll_lock = 1'b1;
        tick(6);
        fire(1'b1, 0, 30);
        tick(28);
        sif.i_fval = 1'b1;
        tick(10);
        sif.i_fval = 1'b0;
        tick(10);
        fire(1'b0, 0, 0);
        tick(20);
        check("cnt_trigger", sif.o_strobe_cnt, 5);

        // Active-low level pulse cut by asynchronous reset
        sif.i_trigger_mode    = 1'b0;
        sif.i_strobe_width    = '0;
        sif.i_strobe_polarity = 1'b1;
        tick(2);
        check("idle_pol1", sif.o_strobe, 1);
        fire(1'b1, 0, 8);
        tick(6);
        check("pulse_pol1", sif.o_strobe, 0);
        tick(2);
        reset = 1'b1;
        #1;
        check("async_rst_strobe", sif.o_strobe, 1);
        check("async_rst_cnt", sif.o_strobe_cnt, 0);
        check("async_rst_lperiod", sif.o_lperiod, 0);
        tick(3);
        reset = 1'b0;
        sif.i_strobe_polarity = 1'b0;
        tick(5);

        // Strobe counter wrap
        sif.i_strobe_width = DW'(2);
        for (int i = 0; i < 15; i++) begin
            fire(1'b1, 0, 2);
            tick(8);
        end
        check("cnt_all_ones", sif.o_strobe_cnt, 15);
        fire(1'b1, 0, 2);
        tick(8);
        check("cnt_wrap", sif.o_strobe_cnt, 0);

        // Line period beyond the counter range saturates
        sif.i_fval = 1'b1;
        tick(5);
        line();
        tick(1095);
        line();
        tick(20);
        check("lperiod_sat", sif.o_lperiod, 1023);
        sif.i_fval = 1'b0;
        tick(20);

        check("sb_drained", sb.size(), 0);
        check("strobe_idle_end", sif.o_strobe, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
